// File: rtl/traffic_light_sequencer.sv
// Timed RED->GREEN->YELLOW controller with pedestrian early-exit and emergency RED hold.
// Outputs registered; phase changes take effect on the edge where the prescaler tick fires.
// No backpressure: inputs are levels sampled every fast_clk cycle.
module traffic_light_sequencer #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int RED_SECS    = 10,
    parameter int GREEN_SECS  = 8,
    parameter int YELLOW_SECS = 3,
    parameter int MIN_GREEN   = 3
) (
    input  logic       fast_clk,
    input  logic       rst_n,
    input  logic       ped_req,
    input  logic       emergency,
    output logic [2:0] light,
    output logic [7:0] secs_left,
    output logic       ped_ack,
    output logic       tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_RED    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_t;

    state_t        state_q;
    logic [2:0]    light_q;
    logic [7:0]    secs_left_q;
    logic [7:0]    elapsed_q;
    logic [PW-1:0] presc_q;
    logic          tick_q;
    logic          ped_pending_q;
    logic          ped_ack_q;

    // Phase timers advance on the same edge that raises the tick strobe.
    logic tick_en;
    logic enter_red;
    logic ped_exit_ok;

    assign tick_en     = (presc_q == PW'(TICK_DIV - 1));
    assign enter_red   = tick_en && (state_q == ST_YELLOW) && (secs_left_q == 8'd1);
    assign ped_exit_ok = ped_pending_q && (({1'b0, elapsed_q} + 9'd1) >= 9'(MIN_GREEN));

    // Free-running prescaler; never disturbed by phase changes.
    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= tick_en ? '0 : presc_q + PW'(1);
            tick_q  <= tick_en;
        end
    end

    // Phase FSM: state, light code and countdown all update together on a tick.
    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RED;
            light_q     <= 3'b100;
            secs_left_q <= 8'(RED_SECS);
            elapsed_q   <= 8'd0;
        end else if (tick_en) begin
            case (state_q)
                ST_GREEN: begin
                    // Emergency beats pedestrian beats natural expiry; all lead to YELLOW.
                    if (emergency || ped_exit_ok || (secs_left_q == 8'd1)) begin
                        state_q     <= ST_YELLOW;
                        light_q     <= 3'b001;
                        secs_left_q <= 8'(YELLOW_SECS);
                        elapsed_q   <= 8'd0;
                    end else begin
                        secs_left_q <= secs_left_q - 8'd1;
                        elapsed_q   <= elapsed_q + 8'd1;
                    end
                end
                ST_YELLOW: begin
                    // YELLOW always runs to completion, emergency or not.
                    if (secs_left_q == 8'd1) begin
                        state_q     <= ST_RED;
                        light_q     <= 3'b100;
                        secs_left_q <= 8'(RED_SECS);
                        elapsed_q   <= 8'd0;
                    end else begin
                        secs_left_q <= secs_left_q - 8'd1;
                        elapsed_q   <= elapsed_q + 8'd1;
                    end
                end
                default: begin
                    // RED: emergency freezes the countdown where it stands.
                    if (!emergency) begin
                        if (secs_left_q == 8'd1) begin
                            state_q     <= ST_GREEN;
                            light_q     <= 3'b010;
                            secs_left_q <= 8'(GREEN_SECS);
                            elapsed_q   <= 8'd0;
                        end else begin
                            secs_left_q <= secs_left_q - 8'd1;
                            elapsed_q   <= elapsed_q + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Pedestrian latch: served on RED entry, where the clear beats a same-edge request.
    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pending_q <= 1'b0;
            ped_ack_q     <= 1'b0;
        end else begin
            ped_ack_q <= 1'b0;
            if (enter_red) begin
                ped_ack_q     <= ped_pending_q;
                ped_pending_q <= 1'b0;
            end else if (ped_req) begin
                ped_pending_q <= 1'b1;
            end
        end
    end

    assign light     = light_q;
    assign secs_left = secs_left_q;
    assign ped_ack   = ped_ack_q;
    assign tick      = tick_q;

`ifndef SYNTHESIS
    // Elaboration-time sanity of the timing parameters.
    initial begin
        if (TICK_DIV < 2)
            $error("traffic_light_sequencer: TICK_DIV=%0d must be >= 2", TICK_DIV);
        if (RED_SECS < 1 || RED_SECS > 255)
            $error("traffic_light_sequencer: RED_SECS=%0d out of 1..255", RED_SECS);
        if (GREEN_SECS < 1 || GREEN_SECS > 255)
            $error("traffic_light_sequencer: GREEN_SECS=%0d out of 1..255", GREEN_SECS);
        if (YELLOW_SECS < 1 || YELLOW_SECS > 255)
            $error("traffic_light_sequencer: YELLOW_SECS=%0d out of 1..255", YELLOW_SECS);
        if (MIN_GREEN < 1 || MIN_GREEN > GREEN_SECS)
            $error("traffic_light_sequencer: MIN_GREEN=%0d out of 1..GREEN_SECS", MIN_GREEN);
    end
`endif

endmodule
